// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulation sequencer.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH     = 10;
   localparam int DEF_ACC_WIDTH = 24;
   localparam int DEF_CNT_WIDTH = 8;

   // Signed limits for a w-bit accumulator; callers keep the low w bits.
   function automatic logic [63:0] sat_max(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int w);
      return ~sat_max(w);
   endfunction

endpackage

// File: rtl/mac_2s_complement.sv
// Conditional two's-complement negation of a WIDTH-bit value.
module mac_2s_complement #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0] din,
   input  logic             neg,
   output logic [WIDTH-1:0] dout
);

   assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/mac_acc_seq.sv
// Burst accumulation sequencer: sign-magnitude terms in, signed sum out over valid/ready.
// Optional MAC_ACC_SAT_EN: saturating adds plus a sticky o_sat flag.
module mac_acc_seq
   import mac_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic [CNT_WIDTH-1:0] i_len,
   input  logic                 i_valid,
   input  logic                 i_sign,
   input  logic [WIDTH-1:0]     i_mant,
   output logic                 o_ready,
   output logic                 o_valid,
   output logic [ACC_WIDTH-1:0] o_result,
   input  logic                 i_ready,
`ifdef MAC_ACC_SAT_EN
   output logic                 o_sat,
`endif
   output logic                 o_busy
);

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d, term, sum;
   logic [ACC_WIDTH-1:0]   mant_ext;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic                   accept, start;

   assign mant_ext = {{(ACC_WIDTH-WIDTH){1'b0}}, i_mant};

   mac_2s_complement #(.WIDTH(ACC_WIDTH)) u_conv (
      .din  (mant_ext),
      .neg  (i_sign),
      .dout (term)
   );

   assign sum = acc_q + term;

`ifdef MAC_ACC_SAT_EN
   localparam logic [63:0]          SAT_MAX64 = sat_max(ACC_WIDTH);
   localparam logic [63:0]          SAT_MIN64 = sat_min(ACC_WIDTH);
   localparam logic [ACC_WIDTH-1:0] SAT_MAX   = SAT_MAX64[ACC_WIDTH-1:0];
   localparam logic [ACC_WIDTH-1:0] SAT_MIN   = SAT_MIN64[ACC_WIDTH-1:0];

   logic overflow;
   logic sat_q;

   // Same-sign operands producing an opposite-sign sum means the add overflowed.
   always_comb begin
      overflow = (acc_q[ACC_WIDTH-1] == term[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
      acc_d    = sum;
      if (overflow)
         acc_d = acc_q[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         sat_q <= 1'b0;
      else if (start)
         sat_q <= 1'b0;
      else if (accept && overflow)
         sat_q <= 1'b1;
   end

   assign o_sat = sat_q;
`else
   assign acc_d = sum;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      o_ready = 1'b0;
      o_valid = 1'b0;
      o_busy  = 1'b0;
      accept  = 1'b0;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               start   = 1'b1;
               state_d = (i_len == '0) ? DONE : ACC;
            end
         end
         ACC: begin
            o_ready = 1'b1;
            o_busy  = 1'b1;
            if (i_valid) begin
               accept = 1'b1;
               if (cnt_q == CNT_WIDTH'(1))
                  state_d = DONE;
            end
         end
         DONE: begin
            o_valid = 1'b1;
            o_busy  = 1'b1;
            if (i_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Accumulator and remaining-term counter; both are reloaded on every accepted start.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         acc_q <= '0;
         cnt_q <= i_len;
      end else if (accept) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q - CNT_WIDTH'(1);
      end
   end

   assign o_result = acc_q;

endmodule

// File: tb/tb_mac_acc_seq.sv
// Scoreboard bench for mac_acc_seq: a default (24-bit) and a 12-bit instance share stimulus.
// Expected sums come from plain integer arithmetic over each burst's term list.
module tb_mac_acc_seq;

   logic        clk = 1'b0;
   logic        i_reset, i_start, i_valid, i_sign, i_ready;
   logic [7:0]  i_len;
   logic [9:0]  i_mant;
   logic        o_ready, o_valid, o_busy;
   logic [23:0] o_result;
   logic        o_ready12, o_valid12, o_busy12;
   logic [11:0] o_result12;
`ifdef MAC_ACC_SAT_EN
   logic        o_sat, o_sat12;
`endif

   typedef struct {
      logic [23:0] r24;
      logic [11:0] r12;
      bit          s24;
      bit          s12;
   } exp_t;

   exp_t sb[$];
   int   term_s[$];
   int   term_m[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mac_acc_seq dut (
      .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_len(i_len),
      .i_valid(i_valid), .i_sign(i_sign), .i_mant(i_mant),
      .o_ready(o_ready), .o_valid(o_valid), .o_result(o_result),
      .i_ready(i_ready),
`ifdef MAC_ACC_SAT_EN
      .o_sat(o_sat),
`endif
      .o_busy(o_busy)
   );

   mac_acc_seq #(.WIDTH(10), .ACC_WIDTH(12), .CNT_WIDTH(8)) dut12 (
      .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_len(i_len),
      .i_valid(i_valid), .i_sign(i_sign), .i_mant(i_mant),
      .o_ready(o_ready12), .o_valid(o_valid12), .o_result(o_result12),
      .i_ready(i_ready),
`ifdef MAC_ACC_SAT_EN
      .o_sat(o_sat12),
`endif
      .o_busy(o_busy12)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sum of the current term list in a w-bit signed register, wrapping or clamping per add.
   function automatic void modelBurst(input int w, output longint res, output bit sat);
      longint maxv, minv, modv, t;
      maxv = (longint'(1) <<< (w - 1)) - 1;
      minv = -maxv - 1;
      modv = longint'(1) <<< w;
      res  = 0;
      sat  = 1'b0;
      foreach (term_s[k]) begin
         t = (term_s[k] != 0) ? -longint'(term_m[k]) : longint'(term_m[k]);
         res += t;
`ifdef MAC_ACC_SAT_EN
         if (res > maxv) begin res = maxv; sat = 1'b1; end
         else if (res < minv) begin res = minv; sat = 1'b1; end
`else
         if (res > maxv) res -= modv;
         else if (res < minv) res += modv;
`endif
      end
   endfunction

   task automatic checkResetOutputs();
      checkOutput("rst_ready", o_ready, 0);
      checkOutput("rst_valid", o_valid, 0);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_result", o_result, 0);
      checkOutput("rst_result12", o_result12, 0);
      checkOutput("rst_valid12", o_valid12, 0);
`ifdef MAC_ACC_SAT_EN
      checkOutput("rst_sat12", o_sat12, 0);
`endif
   endtask

   // Runs one burst from the current posedge+1 point; mode 0 = valid held, 1 = toggling, 2 = random.
   // abort_after >= 0 asserts reset once that many terms have been accepted.
   task automatic applyStimulus(input int len, input int mode, input int ready_wait,
                                input int abort_after, input bit poke);
      int     idx, guard;
      longint r24, r12;
      bit     s24, s12;
      exp_t   e;
      if (abort_after < 0) begin
         modelBurst(24, r24, s24);
         modelBurst(12, r12, s12);
         e.r24 = 24'(r24); e.r12 = 12'(r12); e.s24 = s24; e.s12 = s12;
         sb.push_back(e);
      end
      i_start = 1'b1;
      i_len   = 8'(len);
      @(posedge clk); #1;
      i_start = 1'b0;
      idx = 0;
      guard = 0;
      while (idx < len && guard < 2000) begin
         if (abort_after >= 0 && idx == abort_after) begin
            i_reset = 1'b1;
            i_valid = 1'b0;
            @(posedge clk); #1;
            checkResetOutputs();
            i_reset = 1'b0;
            return;
         end
         checkOutput("ready_in_acc", o_ready, 1);
         i_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
         i_sign  = 1'(term_s[idx]);
         i_mant  = 10'(term_m[idx]);
         i_start = poke ? 1'(guard % 2) : 1'b0;
         i_len   = 8'(len + 3);
         if (i_valid && o_ready) idx++;
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 2000) checkOutput("acc_timeout", 1, 0);
      checkOutput("valid_latency", o_valid, 1);
      checkOutput("ready_in_done", o_ready, 0);
      i_valid = 1'b1;
      i_start = poke;
      repeat (ready_wait) begin
         @(posedge clk); #1;
         checkOutput("valid_held", o_valid, 1);
      end
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
      i_start = 1'b0;
      i_valid = 1'b0;
      checkOutput("busy_after_ack", o_busy, 0);
      checkOutput("valid_after_ack", o_valid, 0);
   endtask

   // Monitor: compares every presented result against the scoreboard head, pops on handshake.
   always @(negedge clk) begin
      if (!i_reset && o_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result: got %0h, expected none", o_result);
         end else begin
            checkOutput("result24", o_result, sb[0].r24);
            checkOutput("result12", o_result12, sb[0].r12);
            checkOutput("valid12", o_valid12, 1);
`ifdef MAC_ACC_SAT_EN
            checkOutput("sat24", o_sat, sb[0].s24);
            checkOutput("sat12", o_sat12, sb[0].s12);
`endif
            if (i_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int len;
      i_reset = 1'b1; i_start = 1'b0; i_len = '0; i_valid = 1'b0;
      i_sign = 1'b0; i_mant = '0; i_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs();
      i_reset = 1'b0;

      term_s = '{0, 1, 0}; term_m = '{5, 3, 10};
      applyStimulus(3, 0, 0, -1, 1'b0);

      term_s.delete(); term_m.delete();
      applyStimulus(0, 0, 0, -1, 1'b0);

      term_s = '{1, 1, 1, 1}; term_m = '{1023, 1023, 1023, 1023};
      applyStimulus(4, 1, 5, -1, 1'b0);

      term_s = '{0, 1, 0, 0, 1}; term_m = '{100, 7, 900, 33, 512};
      applyStimulus(5, 0, 2, -1, 1'b1);

      term_s = '{0, 0, 1, 0, 1}; term_m = '{11, 22, 33, 44, 55};
      applyStimulus(5, 0, 0, 2, 1'b0);
      term_s = '{1}; term_m = '{0};
      applyStimulus(1, 0, 0, -1, 1'b0);

      term_s = '{0, 0, 0}; term_m = '{1023, 1023, 1023};
      applyStimulus(3, 0, 1, -1, 1'b0);

      for (int b = 0; b < 20; b++) begin
         len = int'($urandom_range(0, 12));
         term_s.delete(); term_m.delete();
         for (int k = 0; k < len; k++) begin
            term_s.push_back(int'($urandom_range(0, 1)));
            term_m.push_back(int'($urandom_range(0, 1023)));
         end
         applyStimulus(len, 2, int'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_empty", 64'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
